fpga_wrapper: RTL and testbench

FPGA_WRAPPER -- requirements
Module: fpga_wrapper

---
 rtl/fpga_wrapper.sv | 183 ++++++++++++++++++
 tb/tb_fpga_wrapper.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_wrapper.sv
// Smith-Waterman local aligner (Gotoh affine gaps), one cell per cycle, row-major over S x T.
// Define SW_SCORE_SAT_EN to clamp H at full scale; otherwise H wraps modulo 2^V_E_F_BIT.
module fpga_wrapper #(
  parameter int                 V_E_F_BIT = 12,
  parameter int                 T_LEN     = 16,
  parameter int                 S_LEN     = 32,
  parameter logic [2*T_LEN-1:0] T_SEQ     = 32'h1B4E_D872,
  parameter logic [2*S_LEN-1:0] S_SEQ     = {16'hFFFF, T_SEQ, 16'h0000}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_set_t,
  input  logic                 i_start_cal,
  input  logic [3:0]           i_match,
  input  logic [3:0]           i_mismatch,
  input  logic [3:0]           i_minusAlpha,
  input  logic [3:0]           i_minusBeta,
  output logic                 o_busy,
  output logic                 o_valid,
  output logic [V_E_F_BIT-1:0] o_result
);

  // state  | meaning
  // IDLE   | waiting for set_t / start_cal
  // LOAD_T | copying T_SEQ into t_reg, one base per cycle
  // CALC   | one matrix cell per cycle while cnt != 0
  // DONE   | single-cycle result strobe

  localparam int V  = V_E_F_BIT;
  localparam int W  = V_E_F_BIT + 2;
  localparam int JW = (T_LEN > 1) ? $clog2(T_LEN) : 1;
  localparam int IW = (S_LEN > 1) ? $clog2(S_LEN) : 1;
  localparam int CW = $clog2(T_LEN * S_LEN + 1);

  typedef enum logic [1:0] {IDLE, LOAD_T, CALC, DONE} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic [JW-1:0]  j_idx;
  logic [IW-1:0]  i_idx;
  logic [1:0]     t_reg [T_LEN];
  logic [3:0]     m_q, mm_q, a_q, b_q;
  logic [V-1:0]   h_buf [T_LEN];
  logic [V-1:0]   f_buf [T_LEN];
  logic [V-1:0]   h_left, e_left, diag, run_max;

  logic           cell_en;
  logic [1:0]     s_base, t_base;
  logic [V-1:0]   left_h, left_e, up_h, up_f, dg;
  logic signed [W-1:0] e_w, f_w, h_w, sc;
  logic [V-1:0]   h_st, e_st, f_st;

  function automatic logic signed [W-1:0] smax(input logic signed [W-1:0] x,
                                               input logic signed [W-1:0] y);
    return (x > y) ? x : y;
  endfunction

  function automatic logic signed [W-1:0] ext_v(input logic [V-1:0] x);
    return $signed({2'b00, x});
  endfunction

  function automatic logic signed [W-1:0] ext_p(input logic [3:0] x);
    return $signed({{(W-4){1'b0}}, x});
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_set_t) state_nx = LOAD_T;
               else if (i_start_cal) state_nx = CALC;
      LOAD_T:  if (cnt == '0) state_nx = IDLE;
      CALC:    if (cnt == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_busy  = (state != IDLE);
    o_valid = (state == DONE);
  end

  // Cell datapath: E/F/H from left, up and diagonal neighbours; column 0 sees zero boundary.
  always_comb begin
    cell_en = (state == CALC) && (cnt != '0);
    s_base  = S_SEQ[{i_idx, 1'b0} +: 2];
    t_base  = t_reg[j_idx];
    up_h    = h_buf[j_idx];
    up_f    = f_buf[j_idx];
    left_h  = (j_idx == '0) ? '0 : h_left;
    left_e  = (j_idx == '0) ? '0 : e_left;
    dg      = (j_idx == '0) ? '0 : diag;
    sc      = (s_base == t_base) ? ext_p(m_q) : -ext_p(mm_q);
    e_w     = smax('0, smax(ext_v(left_h) - ext_p(a_q), ext_v(left_e) - ext_p(b_q)));
    f_w     = smax('0, smax(ext_v(up_h) - ext_p(a_q), ext_v(up_f) - ext_p(b_q)));
    h_w     = smax(smax('0, ext_v(dg) + sc), smax(e_w, f_w));
`ifdef SW_SCORE_SAT_EN
    h_st    = (h_w > ext_v('1)) ? '1 : h_w[V-1:0];
`else
    h_st    = h_w[V-1:0];
`endif
    e_st    = e_w[V-1:0];
    f_st    = f_w[V-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      j_idx    <= '0;
      i_idx    <= '0;
      m_q      <= '0;
      mm_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      h_left   <= '0;
      e_left   <= '0;
      diag     <= '0;
      run_max  <= '0;
      o_result <= '0;
      for (int k = 0; k < T_LEN; k++) begin
        t_reg[k] <= '0;
        h_buf[k] <= '0;
        f_buf[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (i_set_t) begin
            cnt   <= CW'(T_LEN - 1);
            j_idx <= '0;
          end else if (i_start_cal) begin
            cnt     <= CW'(T_LEN * S_LEN);
            j_idx   <= '0;
            i_idx   <= '0;
            m_q     <= i_match;
            mm_q    <= i_mismatch;
            a_q     <= i_minusAlpha;
            b_q     <= i_minusBeta;
            h_left  <= '0;
            e_left  <= '0;
            diag    <= '0;
            run_max <= '0;
            for (int k = 0; k < T_LEN; k++) begin
              h_buf[k] <= '0;
              f_buf[k] <= '0;
            end
          end
        end
        LOAD_T: begin
          t_reg[j_idx] <= T_SEQ[{j_idx, 1'b0} +: 2];
          j_idx        <= (j_idx == JW'(T_LEN - 1)) ? '0 : j_idx + 1'b1;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        CALC: begin
          if (cell_en) begin
            h_buf[j_idx] <= h_st;
            f_buf[j_idx] <= f_st;
            h_left       <= h_st;
            e_left       <= e_st;
            diag         <= up_h;
            if (h_st > run_max) run_max <= h_st;
            if (j_idx == JW'(T_LEN - 1)) begin
              j_idx <= '0;
              if (i_idx != IW'(S_LEN - 1)) i_idx <= i_idx + 1'b1;
            end else begin
              j_idx <= j_idx + 1'b1;
            end
            cnt <= cnt - 1'b1;
          end else begin
            o_result <= run_max;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_wrapper.sv
// Bench for fpga_wrapper: default instance plus a 7-bit-score instance, both checked
// against a full-matrix Smith-Waterman/Gotoh model.
module tb_fpga_wrapper;

  logic        clk = 1'b0;
  logic        rst, set_t, start;
  logic [3:0]  match, mism, alpha, beta;
  logic        busy, valid, busy7, valid7;
  logic [11:0] result;
  logic [6:0]  result7;

  int n_tests = 0;
  int n_fail  = 0;
  bit t_loaded;

  logic [31:0] t_bits;
  logic [63:0] s_bits;

`ifdef SW_SCORE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  fpga_wrapper dut (
    .clk(clk), .rst(rst), .i_set_t(set_t), .i_start_cal(start),
    .i_match(match), .i_mismatch(mism), .i_minusAlpha(alpha), .i_minusBeta(beta),
    .o_busy(busy), .o_valid(valid), .o_result(result)
  );

  fpga_wrapper #(.V_E_F_BIT(7)) dut7 (
    .clk(clk), .rst(rst), .i_set_t(set_t), .i_start_cal(start),
    .i_match(match), .i_mismatch(mism), .i_minusAlpha(alpha), .i_minusBeta(beta),
    .o_busy(busy7), .o_valid(valid7), .o_result(result7)
  );

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // Full (S_LEN+1) x (T_LEN+1) score matrices with zero boundary row/column.
  function automatic int sw_model(input int m, input int mm, input int a, input int b,
                                  input bit loaded, input int vb);
    int h [0:32][0:16];
    int e [0:32][0:16];
    int f [0:32][0:16];
    int best, lim, sb, tb, hv;
    best = 0;
    lim  = (1 << vb) - 1;
    for (int i = 0; i <= 32; i++)
      for (int j = 0; j <= 16; j++) begin
        h[i][j] = 0; e[i][j] = 0; f[i][j] = 0;
      end
    for (int i = 1; i <= 32; i++)
      for (int j = 1; j <= 16; j++) begin
        sb = int'(s_bits[2*(i-1) +: 2]);
        tb = loaded ? int'(t_bits[2*(j-1) +: 2]) : 0;
        e[i][j] = imax(0, imax(h[i][j-1] - a, e[i][j-1] - b));
        f[i][j] = imax(0, imax(h[i-1][j] - a, f[i-1][j] - b));
        hv = imax(0, h[i-1][j-1] + ((sb == tb) ? m : -mm));
        hv = imax(hv, imax(e[i][j], f[i][j]));
        if (SAT) hv = (hv > lim) ? lim : hv;
        else     hv = hv % (lim + 1);
        h[i][j] = hv;
        best = imax(best, hv);
      end
    return best;
  endfunction

  // Pulses start with the given parameters and waits (bounded) for the strobe.
  task automatic run_calc(input int m, input int mm, input int a, input int b,
                          output int lat, output bit held,
                          output logic [11:0] r, output logic [6:0] r7, output logic v7);
    logic [11:0] prev;
    prev  = result;
    held  = 1'b1;
    match = 4'(m); mism = 4'(mm); alpha = 4'(a); beta = 4'(b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    while (!valid && lat < 700) begin
      @(posedge clk); #1;
      lat++;
      if (!valid && result !== prev) held = 1'b0;
    end
    r  = result;
    r7 = result7;
    v7 = valid7;
  endtask

  task automatic test_reset();
    rst = 1'b1; set_t = 1'b0; start = 1'b0;
    match = 4'd0; mism = 4'd0; alpha = 4'd0; beta = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    t_loaded = 1'b0;
    n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (valid !== 1'b0)    begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_tests++; if (result !== 12'd0)  begin n_fail++; $display("FAIL reset_result: got %0d want 0", result); end
    n_tests++; if (result7 !== 7'd0)  begin n_fail++; $display("FAIL reset_result7: got %0d want 0", result7); end
  endtask

  // Checks a completed run on both instances plus the post-strobe cycle.
  task automatic check_run(input string tag, input int m, input int mm, input int a, input int b,
                           input int lat, input logic [11:0] r, input logic [6:0] r7, input logic v7);
    int exp12, exp7;
    exp12 = sw_model(m, mm, a, b, t_loaded, 12);
    exp7  = sw_model(m, mm, a, b, t_loaded, 7);
    n_tests++; if (lat !== 513) begin n_fail++; $display("FAIL %s_latency: got %0d want 513", tag, lat); end
    n_tests++; if (int'(r) !== exp12) begin n_fail++; $display("FAIL %s_result: got %0d want %0d", tag, r, exp12); end
    n_tests++; if (v7 !== 1'b1 || int'(r7) !== exp7) begin
      n_fail++; $display("FAIL %s_result7: got %0d (valid %b) want %0d", tag, r7, v7, exp7);
    end
    @(posedge clk); #1;
    n_tests++; if (valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_after: got valid %b busy %b want 0 0", tag, valid, busy);
    end
  endtask

  task automatic test_start_no_t();
    int lat; bit held; logic [11:0] r; logic [6:0] r7; logic v7;
    int m, mm, a, b;
    m = int'($urandom_range(1, 15)); mm = int'($urandom_range(0, 15));
    a = int'($urandom_range(0, 15)); b = int'($urandom_range(0, 15));
    run_calc(m, mm, a, b, lat, held, r, r7, v7);
    check_run("no_t", m, mm, a, b, lat, r, r7, v7);
  endtask

  task automatic count_busy(input string tag, input logic do_set, input logic do_start);
    int bcnt, vcnt;
    bcnt = 0; vcnt = 0;
    set_t = do_set; start = do_start;
    @(posedge clk); #1;
    set_t = 1'b0; start = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (busy) bcnt++;
      if (valid) vcnt++;
      @(posedge clk); #1;
    end
    t_loaded = 1'b1;
    n_tests++; if (bcnt !== 16) begin n_fail++; $display("FAIL %s_busy_cycles: got %0d want 16", tag, bcnt); end
    n_tests++; if (vcnt !== 0)  begin n_fail++; $display("FAIL %s_valid: got %0d strobes want 0", tag, vcnt); end
  endtask

  task automatic test_set_t();
    count_busy("set_t", 1'b1, 1'b0);
  endtask

  task automatic test_priority();
    count_busy("prio", 1'b1, 1'b1);
  endtask

  task automatic test_directed();
    int lat; bit held; logic [11:0] r; logic [6:0] r7; logic v7;
    run_calc(2, 1, 3, 1, lat, held, r, r7, v7);
    n_tests++; if (r !== 12'd32) begin n_fail++; $display("FAIL directed_32: got %0d want 32", r); end
    check_run("directed", 2, 1, 3, 1, lat, r, r7, v7);
  endtask

  task automatic test_zero();
    int lat; bit held; logic [11:0] r; logic [6:0] r7; logic v7;
    n_tests++; if (result !== 12'd32) begin n_fail++; $display("FAIL zero_prior: got %0d want 32", result); end
    run_calc(0, 0, 0, 0, lat, held, r, r7, v7);
    n_tests++; if (held !== 1'b1) begin n_fail++; $display("FAIL zero_hold: result changed before strobe, got %b want 1", held); end
    check_run("zero", 0, 0, 0, 0, lat, r, r7, v7);
  endtask

  task automatic test_ignore();
    int vcnt, exp12, m, mm, a, b;
    logic [11:0] r;
    vcnt = 0;
    set_t = 1'b1;
    @(posedge clk); #1;
    set_t = 1'b0;
    for (int n = 0; n < 30; n++) begin
      start = (n == 3);
      if (valid) vcnt++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_tests++; if (vcnt !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ignore_load: got %0d strobes busy %b want 0 0", vcnt, busy);
    end
    m = int'($urandom_range(1, 15)); mm = int'($urandom_range(0, 15));
    a = int'($urandom_range(0, 15)); b = int'($urandom_range(0, 15));
    match = 4'(m); mism = 4'(mm); alpha = 4'(a); beta = 4'(b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vcnt = 0; r = '0;
    for (int n = 0; n < 700; n++) begin
      start = (n == 100);
      set_t = (n == 200);
      if (n == 101) begin match = 4'd15; mism = 4'd0; alpha = 4'd0; beta = 4'd0; end
      if (valid) begin vcnt++; r = result; end
      @(posedge clk); #1;
    end
    start = 1'b0; set_t = 1'b0;
    exp12 = sw_model(m, mm, a, b, t_loaded, 12);
    n_tests++; if (vcnt !== 1) begin n_fail++; $display("FAIL ignore_calc_strobes: got %0d want 1", vcnt); end
    n_tests++; if (int'(r) !== exp12) begin n_fail++; $display("FAIL ignore_calc_result: got %0d want %0d", r, exp12); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_random();
    int lat; bit held; logic [11:0] r; logic [6:0] r7; logic v7;
    int m, mm, a, b;
    for (int it = 0; it < 4; it++) begin
      m = int'($urandom_range(0, 15)); mm = int'($urandom_range(0, 15));
      a = int'($urandom_range(0, 15)); b = int'($urandom_range(0, 15));
      run_calc(m, mm, a, b, lat, held, r, r7, v7);
      check_run("random", m, mm, a, b, lat, r, r7, v7);
    end
  endtask

  task automatic test_overflow();
    int lat; bit held; logic [11:0] r; logic [6:0] r7; logic v7;
    run_calc(15, 0, 0, 0, lat, held, r, r7, v7);
    n_tests++; if (r !== 12'd240) begin n_fail++; $display("FAIL ovf_wide: got %0d want 240", r); end
`ifdef SW_SCORE_SAT_EN
    n_tests++; if (r7 !== 7'd127) begin n_fail++; $display("FAIL ovf_clamp: got %0d want 127", r7); end
`endif
    check_run("ovf", 15, 0, 0, 0, lat, r, r7, v7);
  endtask

  task automatic test_reset_mid();
    int vcnt, lat; bit held; logic [11:0] r; logic [6:0] r7; logic v7;
    match = 4'd2; mism = 4'd1; alpha = 4'd3; beta = 4'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    t_loaded = 1'b0;
    n_tests++; if (busy !== 1'b0 || busy7 !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b/%b want 0", busy, busy7); end
    n_tests++; if (result !== 12'd0 || result7 !== 7'd0) begin n_fail++; $display("FAIL midrst_result: got %0d/%0d want 0", result, result7); end
    vcnt = 0;
    for (int n = 0; n < 600; n++) begin
      if (valid || valid7 || busy) vcnt++;
      @(posedge clk); #1;
    end
    n_tests++; if (vcnt !== 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d active cycles want 0", vcnt); end
    run_calc(2, 1, 3, 1, lat, held, r, r7, v7);
    check_run("midrst_t_cleared", 2, 1, 3, 1, lat, r, r7, v7);
  endtask

  initial begin
    t_bits = 32'h1B4E_D872;
    s_bits = {16'hFFFF, t_bits, 16'h0000};
    test_reset();
    test_start_no_t();
    test_set_t();
    test_directed();
    test_zero();
    test_priority();
    test_ignore();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
